// File: rtl/plusarg_watchdog_pkg.sv
// Shared types and defaults for the plusarg-driven no-progress watchdog.
// Imported by plusarg_watchdog.
package plusarg_watchdog_pkg;

   localparam int WD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      EXPIRED = 2'b10
   } wd_state_e;

endpackage

// File: rtl/plusarg_watchdog.sv
// No-progress watchdog whose cycle limit comes from a plusarg reader; limit 0 disables it.
// Optional build macro PLUSARG_WATCHDOG_FATAL_EN: simulation-only $fatal on expiry.
module plusarg_watchdog
   import plusarg_watchdog_pkg::*;
#(
   parameter int WIDTH      = WD_WIDTH,
   parameter int WARN_SHIFT = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] limit,
   input  logic             enable,
   input  logic             kick,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             armed,
   output logic             warn,
   output logic             expired,
   output logic             expired_pulse
);

   wd_state_e        state, state_next;
   logic [WIDTH-1:0] count_q, count_next;
   logic [WIDTH-1:0] limit_q, limit_next;
   logic             pulse_q, pulse_next;
   logic [WIDTH:0]   count_inc;
   logic [WIDTH-1:0] warn_level;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count_q <= '0;
         limit_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state   <= state_next;
         count_q <= count_next;
         limit_q <= limit_next;
         pulse_q <= pulse_next;
      end
   end

   // One extra bit keeps the expiry compare exact even at limit_q = 2^WIDTH-1.
   assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      state_next = state;
      count_next = count_q;
      limit_next = limit_q;
      pulse_next = 1'b0;
      case (state)
         IDLE: begin
            count_next = '0;
            if (enable && (limit != '0)) begin
               state_next = ARMED;
               limit_next = limit;
            end
         end
         ARMED: begin
            if (!enable) begin
               state_next = IDLE;
               count_next = '0;
            end else if (kick) begin
               count_next = '0;
            end else if (count_inc == {1'b0, limit_q}) begin
               state_next = EXPIRED;
               count_next = limit_q;
               pulse_next = 1'b1;
            end else begin
               count_next = count_inc[WIDTH-1:0];
            end
         end
         EXPIRED: begin
            // Sticky: only clear leaves; re-arming happens from IDLE a cycle later.
            if (clear) begin
               state_next = IDLE;
               count_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   assign warn_level    = limit_q - (limit_q >> WARN_SHIFT);
   assign count         = count_q;
   assign armed         = (state == ARMED);
   assign expired       = (state == EXPIRED);
   assign expired_pulse = pulse_q;
   assign warn          = armed && (count_q >= warn_level);

`ifdef PLUSARG_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (reset_n && pulse_q) begin
         $display("plusarg_watchdog: no progress for %0d cycles", limit_q);
         $fatal(1, "plusarg_watchdog expired");
      end
   end
`endif
`endif

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Directed bench for plusarg_watchdog: limit-0 disable, expiry timing, kick race,
// sticky/clear, limit resampling, limit 1, and asynchronous reset.
module tb_plusarg_watchdog;

   logic        clock;
   logic        reset_n;
   logic [31:0] limit;
   logic        enable;
   logic        kick;
   logic        clear;
   logic [31:0] count;
   logic        armed;
   logic        warn;
   logic        expired;
   logic        expired_pulse;

   int checks;
   int failures;

   plusarg_watchdog #(.WIDTH(32), .WARN_SHIFT(2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .limit         (limit),
      .enable        (enable),
      .kick          (kick),
      .clear         (clear),
      .count         (count),
      .armed         (armed),
      .warn          (warn),
      .expired       (expired),
      .expired_pulse (expired_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock; outputs are then stable 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      limit   = 32'd0;
      enable  = 1'b0;
      kick    = 1'b0;
      clear   = 1'b0;
      #3;
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000", {armed, warn, expired, expired_pulse});
      end
      checks++;
      if (count !== 32'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d want=0", count);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_limit_zero();
      limit  = 32'd0;
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if ({armed, warn, expired, expired_pulse} !== 4'b0000 || count !== 32'd0) begin
            failures++;
            $display("FAIL limit0 cyc=%0d got flags=%b count=%0d want flags=0000 count=0",
                     i, {armed, warn, expired, expired_pulse}, count);
         end
      end
      enable = 1'b0;
      step();
   endtask

   task automatic test_basic_expiry();
      limit  = 32'd8;
      enable = 1'b1;
      step();
      checks++;
      if (armed !== 1'b1 || count !== 32'd0 || warn !== 1'b0) begin
         failures++;
         $display("FAIL basic_arm got armed=%b count=%0d warn=%b want 1/0/0", armed, count, warn);
      end
      for (int i = 1; i < 8; i++) begin
         step();
         checks++;
         if (armed !== 1'b1 || count !== 32'(i) || warn !== (i >= 6) || expired_pulse !== 1'b0) begin
            failures++;
            $display("FAIL basic_count i=%0d got armed=%b count=%0d warn=%b pulse=%b want 1/%0d/%b/0",
                     i, armed, count, warn, expired_pulse, i, (i >= 6));
         end
      end
      step();
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0011 || count !== 32'd8) begin
         failures++;
         $display("FAIL basic_expire got flags=%b count=%0d want flags=0011 count=8",
                  {armed, warn, expired, expired_pulse}, count);
      end
      step();
      step();
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0010 || count !== 32'd8) begin
         failures++;
         $display("FAIL basic_hold got flags=%b count=%0d want flags=0010 count=8",
                  {armed, warn, expired, expired_pulse}, count);
      end
      enable = 1'b0;
      clear  = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({armed, expired} !== 2'b00 || count !== 32'd0) begin
         failures++;
         $display("FAIL basic_clear got armed=%b expired=%b count=%0d want 0/0/0", armed, expired, count);
      end
   endtask

   task automatic test_kick_race();
      limit  = 32'd4;
      enable = 1'b1;
      step();
      step();
      step();
      step();
      checks++;
      if (count !== 32'd3 || warn !== 1'b1 || armed !== 1'b1) begin
         failures++;
         $display("FAIL kick_pre got count=%0d warn=%b armed=%b want 3/1/1", count, warn, armed);
      end
      kick = 1'b1;
      step();
      kick = 1'b0;
      checks++;
      if (count !== 32'd0 || armed !== 1'b1 || expired !== 1'b0 || expired_pulse !== 1'b0) begin
         failures++;
         $display("FAIL kick_race got count=%0d armed=%b expired=%b pulse=%b want 0/1/0/0",
                  count, armed, expired, expired_pulse);
      end
      step();
      step();
      step();
      checks++;
      if (count !== 32'd3 || expired !== 1'b0) begin
         failures++;
         $display("FAIL kick_recount got count=%0d expired=%b want 3/0", count, expired);
      end
      step();
      checks++;
      if (expired !== 1'b1 || expired_pulse !== 1'b1 || count !== 32'd4) begin
         failures++;
         $display("FAIL kick_expire got expired=%b pulse=%b count=%0d want 1/1/4",
                  expired, expired_pulse, count);
      end
   endtask

   task automatic test_sticky_clear();
      enable = 1'b0;
      kick   = 1'b1;
      step();
      kick = 1'b0;
      step();
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0010 || count !== 32'd4) begin
         failures++;
         $display("FAIL sticky got flags=%b count=%0d want flags=0010 count=4",
                  {armed, warn, expired, expired_pulse}, count);
      end
      enable = 1'b1;
      limit  = 32'd5;
      clear  = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({armed, expired} !== 2'b00 || count !== 32'd0) begin
         failures++;
         $display("FAIL clear_idle got armed=%b expired=%b count=%0d want 0/0/0", armed, expired, count);
      end
      step();
      checks++;
      if (armed !== 1'b1 || count !== 32'd0) begin
         failures++;
         $display("FAIL clear_rearm got armed=%b count=%0d want 1/0", armed, count);
      end
      step();
      step();
      step();
      step();
      checks++;
      if (count !== 32'd4 || warn !== 1'b1 || expired !== 1'b0) begin
         failures++;
         $display("FAIL resample_pre got count=%0d warn=%b expired=%b want 4/1/0", count, warn, expired);
      end
      step();
      checks++;
      if (expired_pulse !== 1'b1 || count !== 32'd5) begin
         failures++;
         $display("FAIL resample_expire got pulse=%b count=%0d want 1/5", expired_pulse, count);
      end
   endtask

   task automatic test_limit_change();
      enable = 1'b0;
      clear  = 1'b1;
      step();
      clear  = 1'b0;
      limit  = 32'd10;
      enable = 1'b1;
      step();
      limit = 32'd3;
      for (int i = 1; i < 10; i++) begin
         step();
         checks++;
         if (count !== 32'(i) || expired !== 1'b0) begin
            failures++;
            $display("FAIL change_count i=%0d got count=%0d expired=%b want %0d/0", i, count, expired, i);
         end
      end
      step();
      checks++;
      if (expired_pulse !== 1'b1 || count !== 32'd10) begin
         failures++;
         $display("FAIL change_expire got pulse=%b count=%0d want 1/10", expired_pulse, count);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (armed !== 1'b0 || expired !== 1'b0) begin
         failures++;
         $display("FAIL change_clear got armed=%b expired=%b want 0/0", armed, expired);
      end
      step();
      step();
      step();
      checks++;
      if (count !== 32'd2 || expired !== 1'b0) begin
         failures++;
         $display("FAIL change_new_pre got count=%0d expired=%b want 2/0", count, expired);
      end
      step();
      checks++;
      if (expired_pulse !== 1'b1 || count !== 32'd3) begin
         failures++;
         $display("FAIL change_new_expire got pulse=%b count=%0d want 1/3", expired_pulse, count);
      end
   endtask

   task automatic test_limit_one();
      clear = 1'b1;
      limit = 32'd1;
      step();
      clear = 1'b0;
      step();
      checks++;
      if (armed !== 1'b1 || warn !== 1'b0 || count !== 32'd0) begin
         failures++;
         $display("FAIL lim1_arm got armed=%b warn=%b count=%0d want 1/0/0", armed, warn, count);
      end
      step();
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0011 || count !== 32'd1) begin
         failures++;
         $display("FAIL lim1_expire got flags=%b count=%0d want flags=0011 count=1",
                  {armed, warn, expired, expired_pulse}, count);
      end
   endtask

   task automatic test_reset_async();
      clear = 1'b1;
      limit = 32'hFFFF_FFFF;
      step();
      clear = 1'b0;
      step();
      step();
      step();
      step();
      checks++;
      if (armed !== 1'b1 || count !== 32'd3 || warn !== 1'b0) begin
         failures++;
         $display("FAIL bigl_count got armed=%b count=%0d warn=%b want 1/3/0", armed, count, warn);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({armed, warn, expired, expired_pulse} !== 4'b0000 || count !== 32'd0) begin
         failures++;
         $display("FAIL async_reset got flags=%b count=%0d want flags=0000 count=0",
                  {armed, warn, expired, expired_pulse}, count);
      end
      enable = 1'b0;
      #1;
      reset_n = 1'b1;
      step();
      checks++;
      if ({armed, expired} !== 2'b00 || count !== 32'd0) begin
         failures++;
         $display("FAIL post_reset got armed=%b expired=%b count=%0d want 0/0/0", armed, expired, count);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_limit_zero();
      test_basic_expiry();
      test_kick_race();
      test_sticky_clear();
      test_limit_change();
      test_limit_one();
      test_reset_async();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
